// File: rtl/rram_test_pkg.sv
// Shared types for the RRAM pulse sequencer: operation codes, FSM states,
// phase-length type and a small op-decode helper.
package rram_test_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_SET   = 2'd1,
    OP_RESET = 2'd2,
    OP_FORM  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_SENSE,
    ST_HOLD,
    ST_RESP
  } state_e;

  // Length of a setup/hold phase in clock cycles.
  typedef int unsigned phase_len_t;

  // SET and FORM both drive the top electrode through the bit line.
  function automatic logic drives_bl(input op_e op);
    return (op == OP_SET) || (op == OP_FORM);
  endfunction

endpackage

// File: rtl/rram_array_pulser_if.sv
// Command/response handshake bundle between the register front-end and the
// pulse sequencer.
interface rram_array_pulser_if
  import rram_test_pkg::*;
#(
  parameter int ROWS    = 2,
  parameter int COLS    = 2,
  parameter int PW_BITS = 8
);
  localparam int RW = $clog2(ROWS) + 1;
  localparam int CW = $clog2(COLS) + 1;

  logic               cmd_valid;
  logic               cmd_ready;
  op_e                cmd_op;
  logic [RW-1:0]      cmd_row;
  logic [CW-1:0]      cmd_col;
  logic [PW_BITS-1:0] cmd_pw;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_data;
  logic               resp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_pw, resp_ready,
    input  cmd_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_pw, resp_ready,
    output cmd_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/rram_pulse_timer.sv
// Phase timer: loaded at the start of each phase, counts down to 1 and
// parks there; done marks the last cycle of the phase.
module rram_pulse_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over counting; saturate at 1 so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q > W'(1)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/rram_array_pulser.sv
// Pulse sequencer for a ROWS x COLS 1T1R RRAM array. Runs one command at a
// time through setup, drive pulse, optional sense and hold phases. All line
// outputs are registered from the current state, so they trail the state by
// one cycle; abort overrides that decode so lines drop on the abort edge.
module rram_array_pulser
  import rram_test_pkg::*;
#(
  parameter int         ROWS      = 2,
  parameter int         COLS      = 2,
  parameter int         PW_BITS   = 8,
  parameter phase_len_t SETUP_CYC = 2,
  parameter phase_len_t HOLD_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  rram_array_pulser_if.slave    bus,
  input  logic                  abort,
  input  logic [COLS-1:0]       sense_in,
  output logic [ROWS-1:0]       wl_en,
  output logic [COLS-1:0]       bl_drv,
  output logic [COLS-1:0]       sl_drv,
  output logic [COLS-1:0]       re_en,
  output logic                  form_hv,
  output logic                  busy
);
  localparam int RW = $clog2(ROWS) + 1;
  localparam int CW = $clog2(COLS) + 1;
  localparam int TW = PW_BITS + 1;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [PW_BITS-1:0] pw_q, pw_d;
  logic               err_q, err_d;
  logic               data_q, data_d;

  logic [ROWS-1:0]    wl_en_q, wl_en_d;
  logic [COLS-1:0]    bl_drv_q, bl_drv_d;
  logic [COLS-1:0]    sl_drv_q, sl_drv_d;
  logic [COLS-1:0]    re_en_q, re_en_d;
  logic               form_hv_q, form_hv_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic               resp_data_q, resp_data_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;

  logic               timer_load;
  logic [TW-1:0]      timer_val;
  logic               timer_done;
  logic               active;
  logic               kill;
  logic               bad_addr;
  logic               sense_bit;

  assign active    = (state_q == ST_SETUP) || (state_q == ST_PULSE) ||
                     (state_q == ST_SENSE) || (state_q == ST_HOLD);
  assign kill      = active && abort;
  assign bad_addr  = (32'(bus.cmd_row) >= 32'(ROWS)) || (32'(bus.cmd_col) >= 32'(COLS));
  assign sense_bit = |(sense_in & (COLS'(1) << col_q));

  rram_pulse_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Next-state logic: phase sequencing, command capture and abort override.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    row_d      = row_q;
    col_d      = col_q;
    pw_d       = pw_q;
    err_d      = err_q;
    data_d     = data_q;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d   = bus.cmd_op;
          row_d  = bus.cmd_row;
          col_d  = bus.cmd_col;
          pw_d   = bus.cmd_pw;
          data_d = 1'b0;
          err_d  = bad_addr;
          if (bad_addr) begin
            state_d = ST_RESP;
          end else begin
            state_d    = ST_SETUP;
            timer_load = 1'b1;
            timer_val  = TW'(SETUP_CYC);
          end
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          state_d    = ST_PULSE;
          timer_load = 1'b1;
          timer_val  = (pw_q == '0) ? TW'(1) : TW'(pw_q);
        end
      end
      ST_PULSE: begin
        if (timer_done) begin
          if (op_q == OP_READ) begin
            state_d = ST_SENSE;
          end else begin
            state_d    = ST_HOLD;
            timer_load = 1'b1;
            timer_val  = TW'(HOLD_CYC);
          end
        end
      end
      ST_SENSE: begin
        data_d     = sense_bit;
        state_d    = ST_HOLD;
        timer_load = 1'b1;
        timer_val  = TW'(HOLD_CYC);
      end
      ST_HOLD: begin
        if (timer_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_valid_q && bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (kill) begin
      state_d    = ST_RESP;
      err_d      = 1'b1;
      data_d     = 1'b0;
      timer_load = 1'b0;
    end
  end

  // Output decode from the current state; abort forces every line low.
  always_comb begin
    wl_en_d      = '0;
    bl_drv_d     = '0;
    sl_drv_d     = '0;
    re_en_d      = '0;
    form_hv_d    = 1'b0;
    if (active && !kill) begin
      wl_en_d   = ROWS'(1) << row_q;
      form_hv_d = (op_q == OP_FORM);
      if (state_q == ST_PULSE && drives_bl(op_q)) bl_drv_d = COLS'(1) << col_q;
      if (state_q == ST_PULSE && op_q == OP_RESET) sl_drv_d = COLS'(1) << col_q;
      if ((state_q == ST_PULSE || state_q == ST_SENSE) && op_q == OP_READ)
        re_en_d = COLS'(1) << col_q;
    end
    resp_valid_d = (state_q == ST_RESP) && !(resp_valid_q && bus.resp_ready);
    resp_err_d   = resp_valid_d && err_q;
    resp_data_d  = resp_valid_d && data_q;
    cmd_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
  end

  // Control and output registers; reset returns to IDLE with all lines low.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      err_q        <= 1'b0;
      data_q       <= 1'b0;
      wl_en_q      <= '0;
      bl_drv_q     <= '0;
      sl_drv_q     <= '0;
      re_en_q      <= '0;
      form_hv_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      data_q       <= data_d;
      wl_en_q      <= wl_en_d;
      bl_drv_q     <= bl_drv_d;
      sl_drv_q     <= sl_drv_d;
      re_en_q      <= re_en_d;
      form_hv_q    <= form_hv_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
    end
  end

  // Captured command fields; only consulted while a command is in flight.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    row_q <= row_d;
    col_q <= col_d;
    pw_q  <= pw_d;
  end

  assign wl_en          = wl_en_q;
  assign bl_drv         = bl_drv_q;
  assign sl_drv         = sl_drv_q;
  assign re_en          = re_en_q;
  assign form_hv        = form_hv_q;
  assign busy           = busy_q;
  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_rram_array_pulser.sv
// Bench for rram_array_pulser: directed cases plus random commands, each
// compared cycle by cycle with a phase-window model of the command timeline.
module tb_rram_array_pulser;
  import rram_test_pkg::*;

  localparam int ROWS    = 2;
  localparam int COLS    = 2;
  localparam int PW_BITS = 8;
  localparam int SETUP   = 2;
  localparam int HOLD    = 2;

  logic            clk;
  logic            resetn;
  logic            abort;
  logic [COLS-1:0] sense_in;
  logic [ROWS-1:0] wl_en;
  logic [COLS-1:0] bl_drv;
  logic [COLS-1:0] sl_drv;
  logic [COLS-1:0] re_en;
  logic            form_hv;
  logic            busy;

  int checks = 0;
  int errors = 0;

  rram_array_pulser_if #(.ROWS(ROWS), .COLS(COLS), .PW_BITS(PW_BITS)) bus ();

  rram_array_pulser #(
    .ROWS(ROWS), .COLS(COLS), .PW_BITS(PW_BITS),
    .SETUP_CYC(SETUP), .HOLD_CYC(HOLD)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .abort    (abort),
    .sense_in (sense_in),
    .wl_en    (wl_en),
    .bl_drv   (bl_drv),
    .sl_drv   (sl_drv),
    .re_en    (re_en),
    .form_hv  (form_hv),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", nm, what, obs, exp);
    end
  endtask

  task automatic chk_idle_lines(input string nm);
    chk(nm, "wl_en", 32'(wl_en), 0);
    chk(nm, "bl_drv", 32'(bl_drv), 0);
    chk(nm, "sl_drv", 32'(sl_drv), 0);
    chk(nm, "re_en", 32'(re_en), 0);
    chk(nm, "form_hv", 32'(form_hv), 0);
  endtask

  // One command from offer to response handshake. k counts clock edges after
  // the accept edge. The model: lines are on in window [1, T] where
  // T = SETUP + max(pw,1) + (READ ? 1 : 0) + HOLD, drive in [SETUP+1, SETUP+pwe],
  // read bias through the extra sense cycle, resp_valid at T+1. A bad address
  // answers at k=1; an abort seen at edge a+1 (a <= T-1) cuts lines after k=a
  // and answers at k=a+2. reset_k >= 0 applies reset at that point instead.
  task automatic run_cmd(input string nm, input int op, input int row, input int col,
                         input int pw, input int abort_k, input int hold_n, input int reset_k);
    int pwe, t_end, resp_k, cut;
    bit bad, aborted, rd, in_pulse;
    logic [31:0] e_wl, e_bl, e_sl, e_re, e_hv, e_data;
    pwe     = (pw == 0) ? 1 : pw;
    rd      = (op == 0);
    bad     = (row >= ROWS) || (col >= COLS);
    t_end   = bad ? 0 : SETUP + pwe + (rd ? 1 : 0) + HOLD;
    aborted = !bad && (abort_k >= 0) && (abort_k <= t_end - 1);
    resp_k  = bad ? 1 : (aborted ? abort_k + 2 : t_end + 1);
    cut     = aborted ? abort_k : t_end;
    e_data  = (rd && !bad && !aborted) ? 32'(sense_in[col]) : 0;

    chk(nm, "cmd_ready_before", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op_e'(op[1:0]);
    bus.cmd_row   = row[1:0];
    bus.cmd_col   = col[1:0];
    bus.cmd_pw    = pw[PW_BITS-1:0];
    tick();
    bus.cmd_valid = 1'b0;

    for (int k = 0; k < resp_k; k++) begin
      in_pulse = (k >= SETUP + 1) && (k <= SETUP + pwe) && (k <= cut);
      e_wl = (k >= 1 && k <= cut) ? (32'd1 << row) : 0;
      e_bl = (in_pulse && (op == 1 || op == 3)) ? (32'd1 << col) : 0;
      e_sl = (in_pulse && op == 2) ? (32'd1 << col) : 0;
      e_re = (rd && k >= SETUP + 1 && k <= SETUP + pwe + 1 && k <= cut) ? (32'd1 << col) : 0;
      e_hv = (op == 3 && k >= 1 && k <= cut) ? 1 : 0;
      chk(nm, $sformatf("wl_en@%0d", k), 32'(wl_en), e_wl);
      chk(nm, $sformatf("bl_drv@%0d", k), 32'(bl_drv), e_bl);
      chk(nm, $sformatf("sl_drv@%0d", k), 32'(sl_drv), e_sl);
      chk(nm, $sformatf("re_en@%0d", k), 32'(re_en), e_re);
      chk(nm, $sformatf("form_hv@%0d", k), 32'(form_hv), e_hv);
      chk(nm, $sformatf("resp_valid@%0d", k), 32'(bus.resp_valid), 0);
      chk(nm, $sformatf("busy@%0d", k), 32'(busy), 1);
      chk(nm, $sformatf("cmd_ready@%0d", k), 32'(bus.cmd_ready), 0);
      chk(nm, "wl_onehot", 32'($countones(wl_en) <= 1), 1);
      chk(nm, "bl_sl_excl", 32'(bl_drv & sl_drv), 0);
      if (k == reset_k) begin
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk_idle_lines({nm, "_rst"});
        chk(nm, "rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk(nm, "rst_busy", 32'(busy), 0);
        chk(nm, "rst_resp_valid", 32'(bus.resp_valid), 0);
        return;
      end
      if (k == abort_k) abort = 1'b1;
      tick();
      abort = 1'b0;
    end

    chk(nm, "resp_valid", 32'(bus.resp_valid), 1);
    chk(nm, "resp_err", 32'(bus.resp_err), 32'(bad || aborted));
    chk(nm, "resp_data", 32'(bus.resp_data), e_data);
    chk_idle_lines({nm, "_resp"});
    for (int i = 0; i < hold_n; i++) begin
      tick();
      chk(nm, "resp_valid_held", 32'(bus.resp_valid), 1);
      chk(nm, "cmd_ready_held", 32'(bus.cmd_ready), 0);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk(nm, "resp_valid_drop", 32'(bus.resp_valid), 0);
    chk(nm, "cmd_ready_after", 32'(bus.cmd_ready), 1);
    chk(nm, "busy_after", 32'(busy), 0);
    chk(nm, "resp_err_after", 32'(bus.resp_err), 0);
  endtask

  initial begin
    int op, row, col, pw, ab, hd;
    resetn         = 1'b0;
    abort          = 1'b0;
    sense_in       = '0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = OP_READ;
    bus.cmd_row    = '0;
    bus.cmd_col    = '0;
    bus.cmd_pw     = '0;
    bus.resp_ready = 1'b0;
    tick();
    tick();
    chk_idle_lines("reset");
    chk("reset", "cmd_ready", 32'(bus.cmd_ready), 1);
    chk("reset", "busy", 32'(busy), 0);
    chk("reset", "resp_valid", 32'(bus.resp_valid), 0);
    chk("reset", "resp_err", 32'(bus.resp_err), 0);
    chk("reset", "resp_data", 32'(bus.resp_data), 0);
    resetn = 1'b1;
    tick();

    run_cmd("set_r1c0", 1, 1, 0, 5, -1, 0, -1);
    sense_in = 2'b10;
    run_cmd("read_r0c1", 0, 0, 1, 3, -1, 2, -1);
    run_cmd("read_r0c0", 0, 0, 0, 3, -1, 1, -1);
    run_cmd("reset_pw0", 2, 1, 1, 0, -1, 0, -1);
    run_cmd("form_r0c1", 3, 0, 1, 4, -1, 0, -1);
    run_cmd("bad_row", 1, 2, 0, 5, -1, 1, -1);
    run_cmd("bad_col", 0, 1, 2, 2, -1, 0, -1);
    run_cmd("abort_set", 1, 0, 1, 200, 3, 10, -1);
    run_cmd("abort_hold", 0, 1, 1, 3, 7, 0, -1);
    run_cmd("abort_resp", 0, 1, 1, 3, 8, 0, -1);
    run_cmd("abort_setup", 3, 1, 0, 2, 0, 0, -1);
    run_cmd("rst_pulse", 1, 1, 1, 20, -1, 0, 5);
    tick();
    run_cmd("after_rst", 2, 0, 0, 1, -1, 0, -1);

    for (int n = 0; n < 20; n++) begin
      op       = int'($urandom_range(0, 3));
      row      = int'($urandom_range(0, 4)) == 0 ? 2 : int'($urandom_range(0, 1));
      col      = int'($urandom_range(0, 4)) == 0 ? 2 : int'($urandom_range(0, 1));
      pw       = int'($urandom_range(0, 6));
      ab       = int'($urandom_range(0, 2)) == 0 ? int'($urandom_range(0, 12)) : -1;
      hd       = int'($urandom_range(0, 3));
      sense_in = 2'($urandom_range(0, 3));
      run_cmd($sformatf("rand%0d", n), op, row, col, pw, ab, hd, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
